basic_gates: RTL and testbench
==============================

# basic_gates

Bitwise two-operand logic unit providing the team's primitive AND and OR gate functions as zero-delay combinational outputs, plus a clocked, op-selectable result register covering the full two-input gate set. It is a leaf cell used by datapath and control blocks that need either a free-running gate output or a registered, selectable logic result. The combinational AND/OR paths are independent of clock and reset.

## Interface

**Parameters**
- `WIDTH`, default 1: operand and result width in bits; all logic is bitwise per lane.

**Ports**
- `clk`, input, 1: single clock; all registers update on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high; clears all registers immediately.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `and_out`, output, WIDTH: combinational `a & b`.
- `or_out`, output, WIDTH: combinational `a | b`.
- `op`, input, 3: operation select for the registered path.
- `en`, input, 1: capture enable for the registered path.
- `y_q`, output, WIDTH: registered logic result.
- `valid_q`, output, 1: high for exactly the cycle after each capture.

## Operation

**Combinational paths**
- `and_out = a & b` and `or_out = a | b`, evaluated per bit lane.
- Both are pure continuous logic: no latch, no register, no dependence on `clk`, `rst`, `en` or `op`.
- Truth table per lane:
  - AND: 00→0, 10→0, 01→0, 11→1.
  - OR: 00→0, 10→1, 01→1, 11→1.

**Registered path, `op` encoding (result f)**
- 0 AND: `a & b`
- 1 OR: `a | b`
- 2 XOR: `a ^ b`
- 3 NAND: `~(a & b)`
- 4 NOR: `~(a | b)`
- 5 XNOR: `~(a ^ b)`
- 6 PASS: `a`
- 7 NOT: `~a`

**Rising edge of `clk` with `rst` low**
- `en=1`: `y_q <= f(op, a, b)`, `valid_q <= 1`.
- `en=0`: `y_q` holds its value, `valid_q <= 0`.

**Reset**
- `rst=1` forces `y_q=0` and `valid_q=0` asynchronously, independent of `clk`.
- The registers stay cleared while `rst` is high; clock edges during reset are ignored.
- Reset does not affect `and_out` or `or_out`.
- Reset asserted mid-stream discards the pending capture.
- The first capture occurs on the first rising edge after `rst` is low and `en=1`.

All eight `op` codes are defined, so there is no illegal state. Result width always equals `WIDTH`; no carries and no cross-lane interaction.

## Timing

- `and_out` and `or_out` settle in the same simulation time step as an input change (zero-delay). They must be correct before any later sample point, including 1 time unit after the change, with no clock edge in between.
- Registered path latency is 1 cycle: inputs sampled at edge N appear on `y_q` after edge N, and `valid_q` is high for that cycle only unless `en` stays high.
- With back-to-back `en=1`, `y_q` updates every cycle and `valid_q` stays high.
- `op`, `a` and `b` must be stable around the capturing edge; they are not re-sampled between edges.
- Reset assertion takes effect without waiting for a clock edge. Deassertion takes effect at the next rising edge.

## Test plan

- **AND truth table** (WIDTH=1): apply {a,b} = 00, 10, 01, 11, waiting 1 time unit each with no clock → `and_out` = 0, 0, 0, 1.
- **OR truth table** (WIDTH=1): apply {a,b} = 00, 10, 01, 11, waiting 1 time unit each → `or_out` = 0, 1, 1, 1.
- **Bitwise width** (WIDTH=8): a=8'hA5, b=8'h3C → `and_out`=8'h24, `or_out`=8'hBD. Then sweep `op` 0..7 with `en=1` → `y_q` = 24, BD, 99, DB, 42, 66, A5, 5A on successive cycles, with `valid_q`=1 throughout.
- **Enable hold** (WIDTH=8): capture op=1 with a=8'h0F, b=8'hF0 → `y_q`=8'hFF. Then drop `en` and change the inputs → `y_q` stays 8'hFF and `valid_q`=0 after the next edge.
- **Async reset mid-operation**: with `y_q`=8'hFF and `valid_q`=1, pulse `rst` between clock edges → `y_q`=0 and `valid_q`=0 immediately; `and_out`/`or_out` keep tracking `a`/`b`. After release, the first enabled edge captures a new result.

Source files
------------

// File: rtl/basic_gates.sv
// Bitwise two-operand logic cell: free-running AND/OR outputs plus a
// clocked, op-selectable result register with a one-cycle capture strobe.
module basic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out,
  input  logic [2:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] y_q,
  output logic             valid_q
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  op_e             op_sel;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] y_d;
  logic             valid_d;

  assign op_sel  = op_e'(op);
  assign and_out = a & b;
  assign or_out  = a | b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    f = '0;
    unique case (op_sel)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_NAND: f = ~(a & b);
      OP_NOR:  f = ~(a | b);
      OP_XNOR: f = ~(a ^ b);
      OP_PASS: f = a;
      OP_NOT:  f = ~a;
      default: f = '0;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    valid_d = en;
    if (en) begin
      y_d = f;
    end
  end

  // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_basic_gates.sv
// Directed bench for basic_gates: truth tables on a 1-bit instance, op sweep,
// enable hold and async reset on an 8-bit instance, scoreboarded expectations.
module tb_basic_gates;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       en;
  logic [7:0] and_out, or_out, y_q;
  logic       valid_q;

  logic       a1, b1;
  logic       and1, or1, y1, valid1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [7:0] y_model;

  basic_gates #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .and_out(and_out), .or_out(or_out),
    .op(op), .en(en), .y_q(y_q), .valid_q(valid_q)
  );

  basic_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .and_out(and1), .or_out(or1),
    .op(3'd0), .en(1'b0), .y_q(y1), .valid_q(valid1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gate_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return x;
      default: return ~x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic [2:0] op_i, input logic [7:0] a_i,
                      input logic [7:0] b_i, input logic en_i);
    exp_t e;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; en = en_i;
    if (en_i) y_model = gate_f(op_i, a_i, b_i);
    sb.push_back('{y: y_model, v: en_i});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_y"}, y_q, e.y);
    check({tag, "_valid"}, {7'd0, valid_q}, {7'd0, e.v});
  endtask

  logic [7:0] sweep_exp [8] = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5, 8'h5A};
  logic [1:0] tt_ab    [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic       tt_and   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       tt_or    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; a = 8'h00; b = 8'h00; op = 3'd1; en = 1'b1; a1 = 1'b0; b1 = 1'b0;
    y_model = 8'h00;

    // Clock edges with en high during reset must be ignored.
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", y_q, 8'h00);
    check("reset_valid", {7'd0, valid_q}, 8'h00);

    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // Truth tables: 1 time unit apart, no clock edge in between.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = tt_ab[i];
      #1;
      check($sformatf("and_tt_%0d", i), {7'd0, and1}, {7'd0, tt_and[i]});
      check($sformatf("or_tt_%0d", i), {7'd0, or1}, {7'd0, tt_or[i]});
    end

    // Bitwise combinational on 8 lanes.
    a = 8'hA5; b = 8'h3C;
    #1;
    check("and_w8", and_out, 8'h24);
    check("or_w8", or_out, 8'hBD);

    // Back-to-back op sweep.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sweep_op%0d", i), 3'(i), 8'hA5, 8'h3C, 1'b1);
      check($sformatf("sweep_tbl%0d", i), y_q, sweep_exp[i]);
    end

    // Enable hold.
    step("hold_cap", 3'd1, 8'h0F, 8'hF0, 1'b1);
    step("hold_off", 3'd0, 8'h12, 8'h34, 1'b0);
    step("hold_off2", 3'd7, 8'hC3, 8'h81, 1'b0);

    // Async reset between edges with registers loaded.
    step("pre_rst", 3'd1, 8'h0F, 8'hF0, 1'b1);
    #2;
    rst = 1'b1; a = 8'h33; b = 8'h55;
    y_model = 8'h00;
    #1;
    check("rst_async_y", y_q, 8'h00);
    check("rst_async_valid", {7'd0, valid_q}, 8'h00);
    check("rst_and", and_out, 8'h11);
    check("rst_or", or_out, 8'h77);
    en = 1'b1; op = 3'd6;
    @(posedge clk);
    #1;
    check("rst_held_y", y_q, 8'h00);
    check("rst_held_valid", {7'd0, valid_q}, 8'h00);

    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    step("post_rst", 3'd2, 8'hA5, 8'h3C, 1'b1);
    step("post_rst_idle", 3'd0, 8'hFF, 8'hFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
